// File: rtl/dwt_sample_framer.sv
// dwt_sample_framer: packs a serial W-bit sample stream into N-sample frames
// held in a ping-pong pair of banks, and presents each full frame as one
// parallel word on a valid/ready output.
// Optional feature macro: DWT_FRAMER_ZERO_PAD_EN -- when defined, flush closes a
// partially filled frame by zero-padding it and emitting it with frame_partial=1;
// when undefined, flush discards the partial frame and frame_partial is 0.
module dwt_sample_framer #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             flush,
  output logic [N*W-1:0]   frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             frame_partial,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_t;

  bank_st_t         st   [2];
  bank_st_t         st_n [2];
  logic [W-1:0]     mem   [2][N];
  logic [W-1:0]     mem_n [2][N];
  logic             wr_sel, wr_sel_n;
  logic             rd_sel, rd_sel_n;
  logic [IDX_W-1:0] fill_idx, fill_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept, handoff, last_slot;
`ifdef DWT_FRAMER_ZERO_PAD_EN
  logic             part   [2];
  logic             part_n [2];
`endif

  assign s_ready     = (st[wr_sel] != FULL);
  assign frame_valid = (st[rd_sel] == FULL);
  assign frame_cnt   = cnt;
`ifdef DWT_FRAMER_ZERO_PAD_EN
  assign frame_partial = part[rd_sel];
`else
  assign frame_partial = 1'b0;
`endif

  // Present the read bank as one packed word, sample 0 in the low bits.
  always_comb begin
    frame_data = '0;
    for (int k = 0; k < N; k++) begin
      frame_data[k*W +: W] = mem[rd_sel][k];
    end
  end

  // Next-state: handoff frees the read bank, accept fills the write bank, and
  // flush then acts on whatever the write bank looks like after the accept.
  always_comb begin
    st_n       = st;
    mem_n      = mem;
    wr_sel_n   = wr_sel;
    rd_sel_n   = rd_sel;
    fill_idx_n = fill_idx;
    cnt_n      = cnt;
`ifdef DWT_FRAMER_ZERO_PAD_EN
    part_n     = part;
`endif
    accept    = s_valid && s_ready;
    handoff   = frame_valid && frame_ready;
    last_slot = (fill_idx == IDX_W'(N - 1));

    if (handoff) begin
      st_n[rd_sel] = EMPTY;
      rd_sel_n     = ~rd_sel;
      cnt_n        = cnt + 1'b1;
    end

    if (accept) begin
      mem_n[wr_sel][fill_idx] = s_data;
      if (last_slot) begin
        st_n[wr_sel] = FULL;
`ifdef DWT_FRAMER_ZERO_PAD_EN
        part_n[wr_sel] = 1'b0;
`endif
        fill_idx_n   = '0;
        wr_sel_n     = ~wr_sel;
      end else begin
        st_n[wr_sel] = FILLING;
        fill_idx_n   = fill_idx + 1'b1;
      end
    end

    // A completed or full bank is never FILLING here, so flush only ever
    // touches a genuinely partial frame.
    if (flush && (st_n[wr_sel] == FILLING)) begin
`ifdef DWT_FRAMER_ZERO_PAD_EN
      for (int k = 0; k < N; k++) begin
        if (IDX_W'(k) >= fill_idx_n) begin
          mem_n[wr_sel][k] = '0;
        end
      end
      st_n[wr_sel]   = FULL;
      part_n[wr_sel] = 1'b1;
      fill_idx_n     = '0;
      wr_sel_n       = ~wr_sel;
`else
      st_n[wr_sel] = EMPTY;
      fill_idx_n   = '0;
`endif
    end
  end

  // State and bank storage; reset clears data too so frame_data reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        st[b] <= EMPTY;
`ifdef DWT_FRAMER_ZERO_PAD_EN
        part[b] <= 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
          mem[b][k] <= '0;
        end
      end
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      fill_idx <= '0;
      cnt      <= '0;
    end else begin
      st       <= st_n;
      mem      <= mem_n;
`ifdef DWT_FRAMER_ZERO_PAD_EN
      part     <= part_n;
`endif
      wr_sel   <= wr_sel_n;
      rd_sel   <= rd_sel_n;
      fill_idx <= fill_idx_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_dwt_sample_framer.sv
// Testbench for dwt_sample_framer (N=8, W=8, CNT_W=4). Directed scenarios then
// randomized traffic, checked against a frame-queue reference model.
// Honours DWT_FRAMER_ZERO_PAD_EN for flush expectations.
module tb_dwt_sample_framer;

  localparam int N = 8;
  localparam int W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             flush = 1'b0;
  logic [N*W-1:0]   frame_data;
  logic             frame_valid;
  logic             frame_ready = 1'b0;
  logic             frame_partial;
  logic [CNT_W-1:0] frame_cnt;

  dwt_sample_framer #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_partial(frame_partial), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Driver intent for the next cycle.
  logic         drv_reset = 1'b1;
  logic         drv_valid = 1'b0;
  logic [W-1:0] drv_data = '0;
  logic         drv_ready = 1'b0;
  logic         drv_flush = 1'b0;
  bit           skip_chk = 1'b1;
  bit           last_acc;

  // Reference model: samples of the frame being collected, and the queue of
  // complete frames awaiting handoff (at most two fit in the framer).
  logic [W-1:0]     cur[$];
  logic [N*W-1:0]   fq_data[$];
  bit               fq_part[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               handed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_cur(input bit partial);
    logic [N*W-1:0] f;
    f = '0;
    for (int i = 0; i < cur.size(); i++) f[i*W +: W] = cur[i];
    fq_data.push_back(f);
    fq_part.push_back(partial);
    cur.delete();
  endtask

  // One clock cycle: drive at the falling edge, check registered outputs,
  // then advance the model by what the coming rising edge should do.
  task automatic tick();
    bit acc, hand;
    @(negedge clk);
    reset = drv_reset; s_valid = drv_valid; s_data = drv_data;
    frame_ready = drv_ready; flush = drv_flush;
    if (!skip_chk) begin
      chk("s_ready", s_ready, fq_data.size() < 2);
      chk("frame_valid", frame_valid, fq_data.size() > 0);
      chk("frame_cnt", frame_cnt, exp_cnt);
      if (fq_data.size() > 0) begin
        chk("frame_data", frame_data, fq_data[0]);
        chk("frame_partial", frame_partial, fq_part[0]);
      end
    end
    skip_chk = 1'b0;
    acc = 1'b0;
    if (drv_reset) begin
      cur.delete(); fq_data.delete(); fq_part.delete();
      exp_cnt = '0;
    end else begin
      acc  = drv_valid && (fq_data.size() < 2);
      hand = (fq_data.size() > 0) && drv_ready;
      if (hand) begin
        void'(fq_data.pop_front());
        void'(fq_part.pop_front());
        exp_cnt++;
        handed++;
      end
      if (acc) begin
        cur.push_back(drv_data);
        if (cur.size() == N) push_cur(1'b0);
      end
      if (drv_flush && cur.size() > 0) begin
`ifdef DWT_FRAMER_ZERO_PAD_EN
        push_cur(1'b1);
`else
        cur.delete();
`endif
      end
    end
    last_acc = acc;
  endtask

  task automatic send(input logic [W-1:0] d);
    drv_valid = 1'b1; drv_data = d;
    last_acc = 1'b0;
    for (int t = 0; t < 50 && !last_acc; t++) tick();
    chk("send_accepted", last_acc, 1'b1);
    drv_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_data", frame_data, 64'h0);
    chk("rst_frame_partial", frame_partial, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 4'd0);
  endtask

  initial begin
    // Reset.
    drv_reset = 1'b1;
    tick(); tick();
    drv_reset = 1'b0;
    tick();
    chk_reset_state();

    // Basic frame with frame_ready held high.
    drv_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(W'(i));
    tick();
    chk("basic_valid", frame_valid, 1'b1);
    chk("basic_data", frame_data, 64'h0807060504030201);
    tick();
    chk("basic_cnt", frame_cnt, 4'd1);

    // Backpressure: two frames fill, the third stalls.
    drv_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(8'h20 + i));
    tick();
    chk("bp_ready_low", s_ready, 1'b0);
    drv_ready = 1'b1;
    for (int i = 16; i < 24; i++) send(W'(8'h20 + i));
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drained", frame_valid, 1'b0);
    chk("bp_cnt", frame_cnt, 4'd4);

    // Flush of a 3-sample partial frame.
    drv_ready = 1'b0;
    send(8'hA1); send(8'hA2); send(8'hA3);
    drv_flush = 1'b1; tick(); drv_flush = 1'b0;
    tick();
`ifdef DWT_FRAMER_ZERO_PAD_EN
    chk("flush_valid", frame_valid, 1'b1);
    chk("flush_data", frame_data, 64'h0000000000A3A2A1);
    chk("flush_partial", frame_partial, 1'b1);
    drv_ready = 1'b1; tick(); drv_ready = 1'b0;
`else
    chk("flush_no_frame", frame_valid, 1'b0);
    for (int i = 0; i < 8; i++) send(W'(8'hB0 + i));
    tick();
    chk("flush_clean_data", frame_data, 64'hB7B6B5B4B3B2B1B0);
    drv_ready = 1'b1; tick(); drv_ready = 1'b0;
`endif
    tick();
    chk("flush_cnt", frame_cnt, 4'd5);

    // Flush coinciding with the 8th sample.
    for (int i = 0; i < 7; i++) send(W'(8'hC0 + i));
    drv_flush = 1'b1; send(8'hC7); drv_flush = 1'b0;
    tick();
    chk("flush8_valid", frame_valid, 1'b1);
    chk("flush8_partial", frame_partial, 1'b0);
    chk("flush8_data", frame_data, 64'hC7C6C5C4C3C2C1C0);
    drv_ready = 1'b1; tick(); drv_ready = 1'b0;
    tick();
    chk("flush8_no_extra", frame_valid, 1'b0);

    // Reset mid-frame with one frame pending.
    for (int i = 0; i < 8; i++) send(W'(8'hD0 + i));
    for (int i = 0; i < 5; i++) send(W'(8'hE0 + i));
    drv_reset = 1'b1; tick(); drv_reset = 1'b0;
    tick();
    chk_reset_state();
    for (int i = 0; i < 8; i++) send(W'(8'h11 + i));
    tick();
    chk("post_rst_data", frame_data, 64'h1817161514131211);
    drv_ready = 1'b1; tick(); drv_ready = 1'b0;
    tick();
    chk("post_rst_cnt", frame_cnt, 4'd1);

    // Randomized traffic; frame_cnt wraps through CNT_W=4 many times.
    handed = 0;
    for (int c = 0; c < 60000 && handed < 1000; c++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_data  = W'($urandom);
      drv_ready = ($urandom_range(0, 1) != 0);
      drv_flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    drv_valid = 1'b0; drv_flush = 1'b0;
    chk("random_frames_done", handed >= 1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
